// File: rtl/alu_op_issue_if.sv
// alu_op_issue_if: fetch-side handshake and decoded-result bus for alu_op_issue.
// illegal_cnt_o exists only when ILLEGAL_COUNT_EN is defined.
interface alu_op_issue_if #(
    parameter int CNT_W = 16
);
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  ALUCtr_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [31:0] imm_o;
    logic        alu_src_o;
    logic        reg_write_o;
    logic        illegal_o;
`ifdef ILLEGAL_COUNT_EN
    logic [CNT_W-1:0] illegal_cnt_o;
`endif

    // Driver side (fetch / testbench / ID-EX consumer)
    modport master (
        output in_valid_i, instr_i, out_ready_i,
        input  in_ready_o, out_valid_o, ALUCtr_o, rs1_o, rs2_o, rd_o, imm_o,
               alu_src_o, reg_write_o, illegal_o
`ifdef ILLEGAL_COUNT_EN
        , input illegal_cnt_o
`endif
    );

    // Decode/issue stage side
    modport slave (
        input  in_valid_i, instr_i, out_ready_i,
        output in_ready_o, out_valid_o, ALUCtr_o, rs1_o, rs2_o, rd_o, imm_o,
               alu_src_o, reg_write_o, illegal_o
`ifdef ILLEGAL_COUNT_EN
        , output illegal_cnt_o
`endif
    );
endinterface

// File: rtl/alu_op_issue.sv
// alu_op_issue: RV32 ALU-op decode into a 2-entry skid buffer with a registered
// in_ready_o. Optional saturating illegal-pop counter under ILLEGAL_COUNT_EN.
module alu_op_issue #(
    parameter int DEPTH = 2,   // only 2 is supported (1-bit pointers)
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    alu_op_issue_if.slave    bus
);
    typedef struct packed {
        logic [2:0]  alu_ctr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alu_src;
        logic        reg_write;
        logic        illegal;
    } entry_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    entry_t     dec;
    entry_t     mem [DEPTH];
    entry_t     head;
    logic       wr_ptr, rd_ptr;
    logic [1:0] count, count_nxt;
    logic       in_rdy_q;
    logic       acc, pop, out_valid;

    wire [6:0] op = bus.instr_i[6:0];
    wire [2:0] f3 = bus.instr_i[14:12];
    wire [6:0] f7 = bus.instr_i[31:25];

    // Combinational decode of the incoming instruction
    always_comb begin
        dec         = '0;
        dec.illegal = 1'b1;
        dec.rs1     = bus.instr_i[19:15];
        dec.rd      = bus.instr_i[11:7];
        if (op == OP_R) begin
            if (f7 == 7'b0000000) begin
                case (f3)
                    3'b111: begin dec.alu_ctr = 3'b000; dec.illegal = 1'b0; end
                    3'b100: begin dec.alu_ctr = 3'b001; dec.illegal = 1'b0; end
                    3'b001: begin dec.alu_ctr = 3'b010; dec.illegal = 1'b0; end
                    3'b000: begin dec.alu_ctr = 3'b011; dec.illegal = 1'b0; end
                    default: ;
                endcase
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                dec.alu_ctr = 3'b100; dec.illegal = 1'b0;
            end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
                dec.alu_ctr = 3'b101; dec.illegal = 1'b0;
            end
            if (!dec.illegal) dec.rs2 = bus.instr_i[24:20];
        end else if (op == OP_I) begin
            if (f3 == 3'b000) begin
                dec.alu_ctr = 3'b110;
                dec.imm     = {{20{bus.instr_i[31]}}, bus.instr_i[31:20]};
                dec.alu_src = 1'b1;
                dec.illegal = 1'b0;
            end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
                dec.alu_ctr = 3'b111;
                dec.imm     = {27'd0, bus.instr_i[24:20]};
                dec.alu_src = 1'b1;
                dec.illegal = 1'b0;
            end
        end
        dec.reg_write = !dec.illegal;
    end

    assign out_valid = (count != 2'd0);
    assign acc       = bus.in_valid_i & in_rdy_q;
    assign pop       = out_valid & bus.out_ready_i;
    assign count_nxt = count + {1'b0, acc} - {1'b0, pop};
    assign head      = mem[rd_ptr];

    // Pointer/occupancy/ready state; flush and reset both empty the buffer
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            in_rdy_q <= 1'b1;
        end else begin
            if (acc) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count    <= count_nxt;
            in_rdy_q <= (count_nxt < 2'd2);
        end
    end

    // Entry storage; contents are don't-care while invalid (outputs are gated)
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && acc) mem[wr_ptr] <= dec;
    end

    // Head entry drives the bus; all fields read as zero while empty
    always_comb begin
        bus.in_ready_o  = in_rdy_q;
        bus.out_valid_o = out_valid;
        bus.ALUCtr_o    = out_valid ? head.alu_ctr   : 3'd0;
        bus.rs1_o       = out_valid ? head.rs1       : 5'd0;
        bus.rs2_o       = out_valid ? head.rs2       : 5'd0;
        bus.rd_o        = out_valid ? head.rd        : 5'd0;
        bus.imm_o       = out_valid ? head.imm       : 32'd0;
        bus.alu_src_o   = out_valid ? head.alu_src   : 1'b0;
        bus.reg_write_o = out_valid ? head.reg_write : 1'b0;
        bus.illegal_o   = out_valid ? head.illegal   : 1'b0;
    end

`ifdef ILLEGAL_COUNT_EN
    logic [CNT_W-1:0] ill_cnt;

    // Saturating count of illegal entries actually handed downstream;
    // a pop coinciding with flush is discarded and not counted
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ill_cnt <= '0;
        else if (pop && !flush_i && head.illegal && ill_cnt != '1)
            ill_cnt <= ill_cnt + 1'b1;
    end

    assign bus.illegal_cnt_o = ill_cnt;
`endif
endmodule
